// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared constants, key codes and FSM state type for the keypad scanner.
// Ports: none (package).
package keypad_pkg;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;

    localparam logic [3:0] KEY_NONE     = 4'd0;
    localparam logic [3:0] KEY_GHOST    = 4'd15;
    localparam logic [3:0] MAX_NOTE_KEY = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKED  = 2'd2
    } key_state_t;

    // True for the keys that carry a note (1..8).
    function automatic logic is_note(input logic [3:0] code);
        return (code != KEY_NONE) && (code <= MAX_NOTE_KEY);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Groups the keypad matrix lines and the game-side key outputs.
// Signals:
//   key_col   - one-hot, active-high column drive (scanner -> matrix)
//   key_row   - row returns, active-high, asynchronous (matrix -> scanner)
//   key_code  - last accepted note key 1..8 (scanner -> game)
//   key_valid - one-clock strobe on a new accepted press
//   key_held  - high while the accepted note key stays pressed
// Modports: master = scanner side, slave = keypad/game side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] key_col;
    logic [NUM_ROWS-1:0] key_row;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_held;

    modport master (
        output key_col,
        output key_code,
        output key_valid,
        output key_held,
        input  key_row
    );

    modport slave (
        input  key_col,
        input  key_code,
        input  key_valid,
        input  key_held,
        output key_row
    );

endinterface

// File: rtl/keypad_debouncer.sv
// keypad_debouncer
// Frame-code stability filter: a new code is accepted once it has been seen
// in DEBOUNCE_SCANS consecutive frames.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   frame_code      - code of the frame that completes this cycle
//   frame_done      - qualifies frame_code (one cycle per frame)
//   debounced_code  - last accepted stable code
//   changed         - one-cycle pulse when debounced_code takes a new value
module keypad_debouncer #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] frame_code,
    input  logic       frame_done,
    output logic [3:0] debounced_code,
    output logic       changed
);
    import keypad_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]    candidate;
    logic [CW-1:0] stable_cnt;
    logic [3:0]    cand_nxt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cand_nxt = candidate;
        cnt_nxt  = stable_cnt;
        if (frame_done) begin
            if (frame_code == candidate) begin
                if (stable_cnt != CNT_MAX)
                    cnt_nxt = stable_cnt + CNT_ONE;
            end else begin
                cand_nxt = frame_code;
                cnt_nxt  = CNT_ONE;
            end
        end
    end

    // The acceptance decision uses the next-state count so the debounced code
    // updates on the same edge that closes the qualifying frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate      <= KEY_NONE;
            stable_cnt     <= '0;
            debounced_code <= KEY_NONE;
            changed        <= 1'b0;
        end else begin
            candidate  <= cand_nxt;
            stable_cnt <= cnt_nxt;
            changed    <= 1'b0;
            if (frame_done && (cnt_nxt == CNT_MAX) && (cand_nxt != debounced_code)) begin
                debounced_code <= cand_nxt;
                changed        <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 3x4 matrix keypad, synchronises and debounces the rows and issues
// one strobe per clean press of a note key (1..8).
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   kp     - keypad_scanner_if.master (key_col, key_row, key_code,
//            key_valid, key_held)
// Parameters:
//   SCAN_DIV       - clocks per column dwell (>= 4)
//   DEBOUNCE_SCANS - identical frames needed to accept a change (>= 1)
module keypad_scanner #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic               clk,
    input logic               reset,
    keypad_scanner_if.master  kp
);
    import keypad_pkg::*;

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [1:0]    COL_LAST = 2'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;

    logic [DW-1:0]       div_cnt;
    logic [1:0]          col_idx;
    logic [NUM_COLS-1:0] col_drv;

    // Partial frame result over the columns already scanned:
    // hit count saturated at 2, and the index of the single hit (if any).
    logic [1:0] acc_hits;
    logic [3:0] acc_idx;

    logic       dwell_end;
    logic       frame_end;
    logic [2:0] col_hits_raw;
    logic [1:0] col_hits;
    logic [2:0] hit_sum;
    logic [1:0] merged_hits;
    logic [3:0] col_key;
    logic [3:0] merged_idx;
    logic [3:0] frame_code;

    logic [3:0] debounced_code;
    logic       deb_changed;

    key_state_t state;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_held_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= kp.key_row;
            row_sync <= row_meta;
        end
    end

    assign dwell_end = (div_cnt == DIV_LAST);
    assign frame_end = dwell_end && (col_idx == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            col_drv <= NUM_COLS'(1);
        end else if (dwell_end) begin
            div_cnt <= '0;
            col_idx <= (col_idx == COL_LAST) ? 2'd0 : col_idx + 2'd1;
            col_drv <= {col_drv[NUM_COLS-2:0], col_drv[NUM_COLS-1]};
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Fold the current column's rows into the running frame result. At the
    // end of the last column this merged value is the frame code itself.
    always_comb begin
        col_hits_raw = 3'($countones(row_sync));
        col_hits     = (col_hits_raw > 3'd1) ? 2'd2 : col_hits_raw[1:0];
        col_key      = KEY_NONE;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_sync[r])
                col_key = 4'(r * NUM_COLS + int'(col_idx) + 1);
        end
        hit_sum     = {1'b0, acc_hits} + {1'b0, col_hits};
        merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_idx  = (col_hits != 2'd0) ? col_key : acc_idx;
        case (merged_hits)
            2'd0:    frame_code = KEY_NONE;
            2'd1:    frame_code = merged_idx;
            default: frame_code = KEY_GHOST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hits <= 2'd0;
            acc_idx  <= KEY_NONE;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
            acc_idx  <= KEY_NONE;
        end else if (dwell_end) begin
            acc_hits <= merged_hits;
            acc_idx  <= merged_idx;
        end
    end

    keypad_debouncer #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debouncer (
        .clk            (clk),
        .reset          (reset),
        .frame_code     (frame_code),
        .frame_done     (frame_end),
        .debounced_code (debounced_code),
        .changed        (deb_changed)
    );

    // The FSM only reacts to debounced changes, so a held key can never
    // produce a second strobe without first passing through code 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (deb_changed) begin
                case (state)
                    IDLE: begin
                        if (is_note(debounced_code)) begin
                            state       <= PRESSED;
                            key_code_q  <= debounced_code;
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                        end else if (debounced_code != KEY_NONE) begin
                            state <= LOCKED;
                        end
                    end
                    PRESSED: begin
                        key_held_q <= 1'b0;
                        state      <= (debounced_code == KEY_NONE) ? IDLE : LOCKED;
                    end
                    LOCKED: begin
                        if (debounced_code == KEY_NONE)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.key_col   = col_drv;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD    = 4;
    localparam int DS    = 3;
    localparam int FRAME = 3 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mask = '0;
    logic [3:0]  row_drv;

    int checks = 0;
    int passes = 0;
    int obs_pulses = 0;

    // reference model state
    logic [3:0] m_cand, m_deb, m_code;
    int         m_cnt;
    logic       m_armed, m_held, m_valid;
    int         m_pulses = 0;

    always #5 clk = ~clk;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // Physical matrix: key k (1..12) sits at row (k-1)/3, column (k-1)%3.
    always_comb begin
        row_drv = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (kp.key_col[c] && mask[r*3+c]) row_drv[r] = 1'b1;
    end
    assign kp.key_row = row_drv;

    always @(negedge clk)
        if (kp.key_valid) obs_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [11:0] key_bit(input int k);
        logic [11:0] one;
        one = 12'd1;
        return one << (k - 1);
    endfunction

    function automatic logic [3:0] frame_code_of(input logic [11:0] msk);
        int n;
        n = $countones(msk);
        if (n == 0) return 4'd0;
        if (n > 1)  return 4'd15;
        for (int i = 0; i < 12; i++)
            if (msk[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_cand = 0; m_cnt = 0; m_deb = 0; m_code = 0;
        m_armed = 1; m_held = 0; m_valid = 0;
    endtask

    // Behaviour at the end of one complete frame with a constant key mask.
    task automatic model_frame(input logic [11:0] msk);
        logic [3:0] fc;
        fc = frame_code_of(msk);
        m_valid = 0;
        if (fc == m_cand) m_cnt = (m_cnt < DS) ? m_cnt + 1 : DS;
        else begin m_cand = fc; m_cnt = 1; end
        if (m_cnt == DS && m_cand != m_deb) begin
            m_deb = m_cand;
            if (m_deb == 0) begin
                m_held = 0; m_armed = 1;
            end else if (m_armed && m_deb <= 8) begin
                m_valid = 1; m_code = m_deb; m_held = 1; m_armed = 0;
                m_pulses++;
            end else begin
                m_held = 0; m_armed = 0;
            end
        end
    endtask

    task automatic run_frames(input logic [11:0] msk, input int n);
        logic [2:0] col_exp;
        logic [2:0] one_c;
        one_c = 3'b001;
        for (int f = 0; f < n; f++) begin
            mask = msk;
            for (int i = 1; i <= FRAME; i++) begin
                @(posedge clk);
                #1;
                col_exp = one_c << ((i / SD) % 3);
                check("key_col", 32'(kp.key_col), 32'(col_exp));
                if (i == 1) begin
                    check("key_valid", 32'(kp.key_valid), 32'(m_valid));
                    check("key_code",  32'(kp.key_code),  32'(m_code));
                    check("key_held",  32'(kp.key_held),  32'(m_held));
                end else if (i == 2) begin
                    check("strobe_width", 32'(kp.key_valid), 32'd0);
                end
            end
            model_frame(msk);
        end
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_col"},   32'(kp.key_col),   32'd1);
        check({tag, "_code"},  32'(kp.key_code),  32'd0);
        check({tag, "_valid"}, 32'(kp.key_valid), 32'd0);
        check({tag, "_held"},  32'(kp.key_held),  32'd0);
    endtask

    initial begin
        logic [11:0] rmask;
        int kind, a, b;

        model_reset();
        #2 reset = 1'b0;
        #1 reset_outputs_check("reset");
        repeat (3) @(posedge clk);
        #1 reset_outputs_check("reset_hold");
        @(negedge clk) reset = 1'b1;

        run_frames('0, 2);

        // clean press of key 4, then release
        run_frames(key_bit(4), 10);
        run_frames('0, 5);

        // bouncing key 2, then held
        for (int f = 0; f < 5; f++)
            run_frames((f % 2 == 0) ? key_bit(2) : 12'd0, 1);
        run_frames(key_bit(2), 6);
        run_frames('0, 4);

        // non-note key 10
        run_frames(key_bit(10), 5);
        run_frames('0, 4);

        // two keys together
        run_frames(key_bit(3) | key_bit(5), 5);
        run_frames('0, 4);

        // rollover 3 -> 3+5 -> 5, then full release and fresh press of 5
        run_frames(key_bit(3), 5);
        run_frames(key_bit(3) | key_bit(5), 4);
        run_frames(key_bit(5), 5);
        run_frames('0, 4);
        run_frames(key_bit(5), 5);
        run_frames('0, 4);

        // reset while key 6 is held in the pressed state
        run_frames(key_bit(6), 5);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 reset_outputs_check("mid_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        run_frames(key_bit(6), 5);
        run_frames('0, 4);

        // randomized key patterns
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: rmask = '0;
                1: rmask = key_bit($urandom_range(1, 8));
                2: rmask = key_bit($urandom_range(9, 12));
                default: begin
                    a = $urandom_range(1, 12);
                    b = $urandom_range(1, 12);
                    if (b == a) b = (a % 12) + 1;
                    rmask = key_bit(a) | key_bit(b);
                end
            endcase
            run_frames(rmask, $urandom_range(1, 4));
        end
        run_frames('0, 5);

        check("pulse_count", 32'(obs_pulses), 32'(m_pulses));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
